// File: rtl/noise_pkg.sv
// Shared types and widths for the noise-table load controller.
// NOISE_LOAD_TIMEOUT_EN adds the ERR state used by the settle timeout.
package noise_pkg;

    localparam int unsigned WordW = 64;
    localparam int unsigned LocW  = 8;

`ifdef NOISE_LOAD_TIMEOUT_EN
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StWaitDone,
        StRun,
        StErr
    } noise_ld_state_t;
`else
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StWaitDone,
        StRun
    } noise_ld_state_t;
`endif

    function automatic logic is_busy(noise_ld_state_t s);
        return (s == StLoad) || (s == StSettle) || (s == StWaitDone);
    endfunction

endpackage

// File: rtl/noise_load_ctrl.sv
// Streams a noise table from the host into the noise core, then enables it.
// Define NOISE_LOAD_TIMEOUT_EN to add the WAIT_DONE timeout and ERR state.
module noise_load_ctrl
    import noise_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WordW-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WordW-1:0] mem_data,
    output logic [LocW-1:0]  location,
    output logic             load_mem,
    input  logic             done_wait,
    output logic             noise_en,
    output logic             running,
    output logic             busy,
    output logic             error,
    output logic [LocW-1:0]  words_loaded
);

    if (NUM_WORDS == 0 || NUM_WORDS > 256 || TIMEOUT_CYC == 0) begin : g_param_err
        $error("noise_load_ctrl: NUM_WORDS must be 1..256 and TIMEOUT_CYC nonzero");
    end

    // One extra bit so a full 256-word table can be counted without wrapping.
    localparam logic [LocW:0] NumWords = NUM_WORDS[LocW:0];

    noise_ld_state_t  state_q, state_d;
    logic [WordW-1:0] mem_data_q, mem_data_d;
    logic [LocW-1:0]  location_q, location_d;
    logic [LocW:0]    cnt_q, cnt_d;
    logic             wr_ready_q, wr_ready_d;
    logic             load_mem_q, load_mem_d;
    logic             noise_en_q, noise_en_d;
    logic             running_q, running_d;
    logic             busy_q, busy_d;
    logic             hs;

`ifdef NOISE_LOAD_TIMEOUT_EN
    localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            error_q, error_d;
`endif

    assign hs = wr_valid && wr_ready_q && (state_q == StLoad);

    always_comb begin
        state_d    = state_q;
        mem_data_d = mem_data_q;
        location_d = location_q;
        cnt_d      = cnt_q;
`ifdef NOISE_LOAD_TIMEOUT_EN
        tmo_d      = '0;
`endif
        // stop takes priority over everything, and the partial count is kept.
        if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StLoad;
                        cnt_d   = '0;
                    end
                end
                StLoad: begin
                    if (hs) begin
                        mem_data_d = wr_data;
                        location_d = cnt_q[LocW-1:0];
                        if (cnt_q < NumWords) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (cnt_d >= NumWords) begin
                            state_d = StSettle;
                        end
                    end
                end
                StSettle: state_d = StWaitDone;
                StWaitDone: begin
                    if (done_wait) begin
                        state_d = StRun;
                    end
`ifdef NOISE_LOAD_TIMEOUT_EN
                    else if (tmo_q == TmoLast) begin
                        state_d = StErr;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
`endif
                end
                StRun: begin
                    if (start) begin
                        state_d = StLoad;
                        cnt_d   = '0;
                    end
                end
`ifdef NOISE_LOAD_TIMEOUT_EN
                StErr: begin
                    if (start) begin
                        state_d = StLoad;
                        cnt_d   = '0;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        wr_ready_d = (state_d == StLoad);
        load_mem_d = (state_d == StLoad) || (state_d == StSettle);
        noise_en_d = (state_d == StWaitDone) || (state_d == StRun);
        running_d  = (state_d == StRun);
        busy_d     = is_busy(state_d);
`ifdef NOISE_LOAD_TIMEOUT_EN
        error_d    = (state_d == StErr);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mem_data_q <= '0;
            location_q <= '0;
            cnt_q      <= '0;
            wr_ready_q <= 1'b0;
            load_mem_q <= 1'b0;
            noise_en_q <= 1'b0;
            running_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef NOISE_LOAD_TIMEOUT_EN
            tmo_q      <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_data_q <= mem_data_d;
            location_q <= location_d;
            cnt_q      <= cnt_d;
            wr_ready_q <= wr_ready_d;
            load_mem_q <= load_mem_d;
            noise_en_q <= noise_en_d;
            running_q  <= running_d;
            busy_q     <= busy_d;
`ifdef NOISE_LOAD_TIMEOUT_EN
            tmo_q      <= tmo_d;
            error_q    <= error_d;
`endif
        end
    end

    assign wr_ready     = wr_ready_q;
    assign mem_data     = mem_data_q;
    assign location     = location_q;
    assign load_mem     = load_mem_q;
    assign noise_en     = noise_en_q;
    assign running      = running_q;
    assign busy         = busy_q;
    assign words_loaded = cnt_q[LocW-1:0];
`ifdef NOISE_LOAD_TIMEOUT_EN
    assign error        = error_q;
`else
    assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_noise_load_ctrl.sv
// Bench for noise_load_ctrl: directed scenarios plus random traffic, all
// checked against a queue-based model of the accepted table words.
module tb_noise_load_ctrl;

    localparam int unsigned NW = 16;
    localparam int unsigned TC = 32;

    localparam int MIdle   = 0;
    localparam int MLoad   = 1;
    localparam int MSettle = 2;
    localparam int MWait   = 3;
    localparam int MRun    = 4;
    localparam int MErr    = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, wr_valid, done_wait;
    logic [63:0] wr_data;
    logic        wr_ready, load_mem, noise_en, running, busy, error;
    logic [63:0] mem_data;
    logic [7:0]  location, words_loaded;

    int          n_checks = 0;
    int          n_fail   = 0;
    string       step     = "init";

    // Model: mode, the list of words accepted this load, last word/index seen.
    int          m_mode;
    logic [63:0] q[$];
    logic [63:0] e_mem;
    logic [7:0]  e_loc;
    int          tmo;
    int          lm_cnt;

    always #5 clk = ~clk;

    noise_load_ctrl #(
        .NUM_WORDS  (NW),
        .TIMEOUT_CYC(TC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .mem_data    (mem_data),
        .location    (location),
        .load_mem    (load_mem),
        .done_wait   (done_wait),
        .noise_en    (noise_en),
        .running     (running),
        .busy        (busy),
        .error       (error),
        .words_loaded(words_loaded)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = MIdle;
        q.delete();
        e_mem = '0;
        e_loc = '0;
        tmo   = 0;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        if (stop) begin
            m_mode = MIdle;
        end else begin
            case (m_mode)
                MIdle: if (start) begin m_mode = MLoad; q.delete(); end
                MLoad: if (wr_valid) begin
                    e_loc = 8'(q.size());
                    e_mem = wr_data;
                    q.push_back(wr_data);
                    if (q.size() == int'(NW)) m_mode = MSettle;
                end
                MSettle: begin m_mode = MWait; tmo = 0; end
                MWait: begin
                    if (done_wait) m_mode = MRun;
`ifdef NOISE_LOAD_TIMEOUT_EN
                    else begin
                        tmo++;
                        if (tmo == int'(TC)) m_mode = MErr;
                    end
`endif
                end
                MRun, MErr: if (start) begin m_mode = MLoad; q.delete(); end
                default: m_mode = MIdle;
            endcase
        end
    endtask

    task automatic check_all();
        chk("wr_ready", 64'(wr_ready), 64'(m_mode == MLoad));
        chk("load_mem", 64'(load_mem), 64'(m_mode == MLoad || m_mode == MSettle));
        chk("noise_en", 64'(noise_en), 64'(m_mode == MWait || m_mode == MRun));
        chk("running", 64'(running), 64'(m_mode == MRun));
        chk("busy", 64'(busy), 64'(m_mode == MLoad || m_mode == MSettle || m_mode == MWait));
        chk("error", 64'(error), 64'(m_mode == MErr));
        chk("mem_data", mem_data, e_mem);
        chk("location", 64'(location), 64'(e_loc));
        chk("words_loaded", 64'(words_loaded), 64'(q.size()));
    endtask

    task automatic cyc(input logic st, input logic sp, input logic wv,
                       input logic [63:0] wd, input logic dw);
        start     = st;
        stop      = sp;
        wr_valid  = wv;
        wr_data   = wd;
        done_wait = dw;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (load_mem) lm_cnt++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        done_wait = 1'b0;
        model_reset();
        #1;
        step = "reset";
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Nominal load of words 0..15 with wr_valid held high.
        step = "nominal";
        lm_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 64'(i), 1'b0);
        chk("last_loc", 64'(location), 64'd15);
        cyc(1'b0, 1'b0, 1'b1, 64'hdead, 1'b0);  // settle; wr_valid ignored
        idle_cycles(5);
        chk("load_mem_cycles", 64'(lm_cnt), 64'd17);
        cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        chk("running_nom", 64'(running), 64'd1);
        chk("words_nom", 64'(words_loaded), 64'd16);
        cyc(1'b0, 1'b0, 1'b1, 64'hbeef, 1'b0);  // wr_valid in RUN ignored

        // Reload from RUN; noise_en must drop with LOAD entry.
        step = "reload";
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("noise_en_reload", 64'(noise_en), 64'd0);
        chk("words_reload", 64'(words_loaded), 64'd0);

        // Backpressure: alternating valid.
        step = "backpressure";
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 1'(i % 2), 64'h100 + 64'(i), 1'b0);
        chk("bp_words", 64'(words_loaded), 64'd16);
        chk("bp_last_loc", 64'(location), 64'd15);
        idle_cycles(2);
        cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);

        // Abort after 7 words, then reload from location 0.
        step = "abort";
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 64'h200 + 64'(i), 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        chk("abort_load_mem", 64'(load_mem), 64'd0);
        chk("abort_words", 64'(words_loaded), 64'd7);
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 64'h300, 1'b0);
        chk("abort_reload_loc", 64'(location), 64'd0);

        // start+stop together in LOAD: stop wins.
        step = "start_stop";
        cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        chk("ss_busy", 64'(busy), 64'd0);

        // start ignored in LOAD, then settle timeout (or indefinite wait).
        step = "timeout";
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'(i == 4), 1'b0, 1'b1, 64'h400 + 64'(i), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);  // SETTLE -> WAIT_DONE
        idle_cycles(31);
        chk("tmo_err_early", 64'(error), 64'd0);
        idle_cycles(1);
`ifdef NOISE_LOAD_TIMEOUT_EN
        chk("tmo_err_32", 64'(error), 64'd1);
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("tmo_cleared", 64'(error), 64'd0);
`else
        chk("tmo_err_32", 64'(error), 64'd0);
        idle_cycles(8);
        chk("tmo_still_wait", 64'(busy), 64'd1);
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);  // ignored in WAIT_DONE
        cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
`endif

        // Asynchronous reset mid-load after 3 words.
        step = "reset_mid";
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 64'h500 + 64'(i), 1'b0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 64'h600, 1'b1);

        // Random traffic.
        step = "random";
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(19) == 0), 1'($urandom_range(59) == 0),
                1'($urandom_range(1)), {$urandom(), $urandom()},
                1'($urandom_range(5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
